// File: rtl/level_display.sv
// level_display: rate-limited 4-digit X.XXX level readout with peak-hold,
// active-low seven-segment outputs, PWM dimming and an over-level flag.
module level_display #(
    parameter int          UPDATE_CYCLES = 12000,
    parameter int          HOLD_CYCLES   = 96000,
    parameter logic [15:0] OVER_THRESH   = 16'h2000
) (
    input  logic       clk_48,
    input  logic       reset_n,
    input  logic [3:0] num3,
    input  logic [3:0] num2,
    input  logic [3:0] num1,
    input  logic [3:0] num0,
    input  logic       peak_en,
    input  logic [2:0] bright,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       dp3,
    output logic       over
);
    localparam int UW = UPDATE_CYCLES > 1 ? $clog2(UPDATE_CYCLES) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    typedef enum logic [1:0] {BLANK, TRACK, HOLD} state_t;
    state_t        state;
    logic [UW-1:0] upd_cnt;
    logic [HW-1:0] hold_cnt;
    logic [2:0]    pwm_cnt;
    logic [15:0]   disp;
    logic [15:0]   sample;
    logic          tick;
    logic          hold_done;
    logic          reload;
    logic          vis;
    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
    endfunction
    assign sample    = {num3, num2, num1, num0};
    assign tick      = upd_cnt == UW'(UPDATE_CYCLES - 1);
    assign hold_done = hold_cnt == HW'(HOLD_CYCLES);
    // In HOLD a tick reloads on leaving, on a new peak, or once the hold has expired
    assign reload    = tick & (~peak_en | (sample > disp) | hold_done);
    assign vis       = ((bright == 3'd7) | (pwm_cnt < bright)) & (state != BLANK);
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= BLANK;
            upd_cnt  <= '0;
            hold_cnt <= '0;
            pwm_cnt  <= '0;
            disp     <= '0;
            over     <= 1'b0;
            hex3     <= 7'h7F;
            hex2     <= 7'h7F;
            hex1     <= 7'h7F;
            hex0     <= 7'h7F;
            dp3      <= 1'b1;
        end else begin
            upd_cnt <= tick ? '0 : upd_cnt + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            hex3    <= vis ? seg(disp[15:12]) : 7'h7F;
            hex2    <= vis ? seg(disp[11:8])  : 7'h7F;
            hex1    <= vis ? seg(disp[7:4])   : 7'h7F;
            hex0    <= vis ? seg(disp[3:0])   : 7'h7F;
            dp3     <= ~vis;
            case (state)
                BLANK, TRACK: begin
                    if (tick) begin
                        disp     <= sample;
                        over     <= sample >= OVER_THRESH;
                        hold_cnt <= '0;
                        state    <= peak_en ? HOLD : TRACK;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_done ? hold_cnt : hold_cnt + 1'b1;
                    if (reload) begin
                        disp <= sample;
                        over <= sample >= OVER_THRESH;
                    end
                    if (tick && !peak_en)
                        state <= TRACK;
                    else if (reload)
                        hold_cnt <= '0;
                end
                default: state <= BLANK;
            endcase
        end
    end
endmodule

// File: tb/tb_level_display.sv
// tb_level_display: scoreboard bench for level_display with a tick-level
// reference model; expected display words are queued at each tick.
module tb_level_display;
    logic       clk_48 = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] num3, num2, num1, num0;
    logic       peak_en;
    logic [2:0] bright;
    logic [6:0] hex3, hex2, hex1, hex0;
    logic       dp3, over;

    level_display #(.UPDATE_CYCLES(4), .HOLD_CYCLES(10), .OVER_THRESH(16'h2000)) dut (
        .clk_48(clk_48), .reset_n(reset_n),
        .num3(num3), .num2(num2), .num1(num1), .num0(num0),
        .peak_en(peak_en), .bright(bright),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .dp3(dp3), .over(over)
    );

    always #5 clk_48 = ~clk_48;

    typedef struct {
        int          due;
        logic [29:0] exp;
    } sb_t;
    sb_t         q[$];
    int          errors = 0;
    int          checks = 0;
    int          e = 0;
    int          m_state = 0;
    int          m_load = 0;
    logic [15:0] m_disp = '0;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic logic [29:0] expect_of(input logic [15:0] v);
        return {seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0]), 1'b0, v >= 16'h2000};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, e, got, exp);
        end
    endtask

    // Hold age seen at edge n is the number of edges since the last load minus one, capped at 10
    task automatic model_tick(input int n);
        logic [15:0] s;
        int          age;
        s = {num3, num2, num1, num0};
        if (m_state != 2) begin
            m_disp = s;
            if (peak_en) begin
                m_state = 2;
                m_load  = n;
            end else
                m_state = 1;
        end else begin
            age = n - m_load - 1;
            if (age > 10) age = 10;
            if (!peak_en) begin
                m_disp  = s;
                m_state = 1;
            end else if (s > m_disp || age == 10) begin
                m_disp = s;
                m_load = n;
            end
        end
        q.push_back('{n + 1, expect_of(m_disp)});
    endtask

    task automatic step();
        int         n;
        logic [2:0] b;
        sb_t        t;
        n = e + 1;
        b = bright;
        if (n % 4 == 0) model_tick(n);
        @(posedge clk_48);
        #1;
        e = n;
        if (q.size() > 0 && q[0].due == e) begin
            t = q.pop_front();
            if (b == 3'd7) check("display", {2'b00, hex3, hex2, hex1, hex0, dp3, over}, {2'b00, t.exp});
        end
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic set(input logic [15:0] v, input logic pk);
        {num3, num2, num1, num0} = v;
        peak_en = pk;
    endtask

    task automatic blank_edges(input int k);
        repeat (k) begin
            step();
            check("blank", {3'b000, hex3, hex2, hex1, hex0, dp3}, {3'b000, 29'h1FFFFFFF});
        end
    endtask

    initial begin
        int on_cnt;
        int dp_cnt;
        set(16'h1234, 1'b0);
        bright = 3'd7;
        repeat (3) @(posedge clk_48);
        #1;
        check("reset", {2'b00, hex3, hex2, hex1, hex0, dp3, over}, {2'b00, 30'h3FFFFFFE});
        @(negedge clk_48);
        reset_n = 1'b1;
        blank_edges(4);
        run(8);
        set(16'h2500, 1'b0);
        run(4);
        check("over_2500", {31'd0, over}, 32'd1);
        set(16'h1000, 1'b0);
        run(4);
        check("over_1000", {31'd0, over}, 32'd0);
        set(16'h2500, 1'b1);
        run(4);
        set(16'h1000, 1'b1);
        run(20);
        set(16'h2500, 1'b1);
        run(4);
        set(16'h1000, 1'b1);
        run(4);
        set(16'h3000, 1'b1);
        run(4);
        set(16'h1000, 1'b1);
        run(20);
        set(16'h12A4, 1'b0);
        run(8);
        check("dash_hex1", {25'd0, hex1}, 32'h3F);
        bright = 3'd3;
        on_cnt = 0;
        dp_cnt = 0;
        repeat (8) begin
            step();
            if (hex0 !== 7'h7F) begin
                on_cnt++;
                check("pwm_pattern", {25'd0, hex0}, {25'd0, seg(m_disp[3:0])});
            end
            if (dp3 === 1'b0) dp_cnt++;
        end
        check("pwm3_on", on_cnt, 3);
        check("pwm3_dp", dp_cnt, 3);
        bright = 3'd0;
        on_cnt = 0;
        dp_cnt = 0;
        repeat (8) begin
            step();
            if ({hex3, hex2, hex1, hex0} !== 28'hFFFFFFF) on_cnt++;
            if (dp3 !== 1'b1) dp_cnt++;
        end
        check("pwm0_on", on_cnt, 0);
        check("pwm0_dp", dp_cnt, 0);
        bright = 3'd7;
        run(4);
        set(16'h2500, 1'b1);
        run(10);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset", {2'b00, hex3, hex2, hex1, hex0, dp3, over}, {2'b00, 30'h3FFFFFFE});
        @(negedge clk_48);
        reset_n = 1'b1;
        e       = 0;
        m_state = 0;
        m_disp  = '0;
        q.delete();
        blank_edges(4);
        run(8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/level_display.md
# level_display

Downstream display stage for the output-level meter. It takes the four BCD digits produced by the level-ratio block, which encode gain ×1000 and are displayed as X.XXX. It rate-limits display updates so the reading is legible, and provides an optional peak-hold with timeout. It drives four active-low seven-segment displays with a fixed decimal point, PWM brightness control and an over-level flag.

## Interface
- UPDATE_CYCLES, 12000: clk_48 cycles between display updates (250 ms at 48 kHz).
- HOLD_CYCLES, 96000: peak-hold duration in clk_48 cycles (2 s).
- OVER_THRESH, 16'h2000: BCD threshold {d3,d2,d1,d0}; displayed value ≥ threshold asserts over (2.000 = +6 dB).
- clk_48  in  1  clock, 48 kHz sample-rate clock.
- reset_n  in  1  reset, asynchronous, active-low.
- num3, num2, num1, num0  in  4 each  BCD digits, thousands to units, from the level-ratio block.
- peak_en  in  1  1 = peak-hold mode, 0 = track mode; sampled only on update ticks.
- bright  in  3  brightness; 7 = always on, 0 = off.
- hex3, hex2, hex1, hex0  out  7 each  segments, active-low; bit0 = a … bit6 = g.
- dp3  out  1  decimal point after hex3, active-low.
- over  out  1  displayed value ≥ OVER_THRESH.

## Operation
- upd_cnt counts 0..UPDATE_CYCLES-1 and wraps. tick = (upd_cnt == UPDATE_CYCLES-1).
- sample = {num3,num2,num1,num0} captured at tick. Comparisons are unsigned on the 16-bit BCD word; digit-lexicographic order equals numeric order.
- A digit >9 compares by its raw nibble and is decoded as dash (7'h3F).
- disp is the 16-bit displayed value register.
- State BLANK, entered at reset:
  - All segments and dp3 off.
  - On tick: disp ← sample; go to TRACK if peak_en=0, else go to HOLD with hold_cnt ← 0.
- State TRACK: on tick, disp ← sample. If peak_en=1 at that tick, also go to HOLD with hold_cnt ← 0.
- State HOLD:
  - hold_cnt increments every cycle and saturates at HOLD_CYCLES.
  - On tick with peak_en=0: disp ← sample, go to TRACK.
  - On tick with peak_en=1 and (sample > disp or hold_cnt == HOLD_CYCLES): disp ← sample, hold_cnt ← 0.
  - Otherwise disp is held. Equal samples do not restart the hold.
- over ← (disp ≥ OVER_THRESH). Registered alongside disp; 0 in BLANK.
- Decode table, active-low:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10
  - >9 = 3F (dash), off = 7F
- No leading-zero blanking.
- PWM:
  - pwm_cnt is a free-running 3-bit counter.
  - en = (bright == 7) | (pwm_cnt < bright).
  - When en=0, hex = 7'h7F and dp3 = 1.
- Output register:
  - hex[i] ← en & state≠BLANK ? decode(disp digit i) : 7'h7F.
  - dp3 ← ~(en & state≠BLANK).

## Timing
- Reset values:
  - Outputs: hex* = 7'h7F, dp3 = 1, over = 0.
  - Internal: disp = 0, upd_cnt = 0, hold_cnt = 0, pwm_cnt = 0, state = BLANK.
- The first tick occurs at the UPDATE_CYCLES-th rising edge after reset deasserts. disp and over update at that edge.
- hex and dp3 reflect the new disp one cycle later: two-edge latency from digit capture to pins.
- Inputs between ticks are ignored. Digits must be stable at the tick edge; upstream updates about once per second.
- A tick coinciding with hold expiry counts as expiry.
- A tick coinciding with a higher sample reloads disp; both conditions behave identically.
- bright changes take effect on the next cycle.
- reset_n low mid-HOLD: immediate asynchronous return to reset values; the display blanks until the next first tick.

## Test plan
Parameters for all scenarios: UPDATE_CYCLES=4, HOLD_CYCLES=10, bright=7 unless stated.
- Reset, then digits 1,2,3,4, peak_en=0 -> hex* = 7F and dp3 = 1 through edge 4. From edge 5: hex3=79, hex2=24, hex1=30, hex0=19, dp3=0, over=0.
- Track mode, 2.500 then 1.000 on successive ticks -> display follows each tick: hex3=24 then 79. over=1 during 2.500, then 0.
- peak_en=1, 2.500 then 1.000 held -> 2.500 persists until the first tick with hold_cnt=10, then 1.000. A 3.000 arriving mid-hold displays immediately and restarts the hold.
- Digit num1 = 4'hA -> hex1 = 3F; other digits decode normally.
- bright=3 -> each hex output is a valid pattern for exactly 3 of every 8 cycles and 7F otherwise. bright=0 -> constant 7F, dp3=1.
- reset_n pulsed low mid-HOLD -> outputs immediately hex* = 7F, dp3 = 1, over = 0. Normal display resumes 5 edges after release.
